xnor_match_monitor: RTL and testbench
=====================================

Name: xnor_match_monitor

Overview:
- Downstream checking stage for the 2-input XNOR gate: consumes the reference output bit and the DUT output bit each valid cycle, and registers a per-sample XNOR match.
- Accumulates pass/fail statistics over a bounded or open-ended sample window.
- Provides a synthesizable, on-chip equivalent of the bench's mismatch bookkeeping, so gate-under-test runs can be self-checked in hardware.

Parameters:
- CNT_W, 16, width of all counters and index outputs.
- WINDOW, 0, number of samples per run; 0 = unbounded (run ends only on stop). Must fit in CNT_W bits.

Ports:
- clk  in  1  rising-edge clock
- areset_n  in  1  asynchronous reset, active-low
- start  in  1  single-cycle pulse; begins a run
- stop  in  1  single-cycle pulse; ends a run
- in_valid  in  1  ref_bit/dut_bit valid this cycle
- ref_bit  in  1  reference gate output
- dut_bit  in  1  gate-under-test output
- busy  out  1  high in RUN
- done  out  1  high in DONE
- match_valid  out  1  registered in_valid qualified by RUN
- match  out  1  registered ~(ref_bit ^ dut_bit)
- err_sticky  out  1  set on first mismatch of a run
- sample_cnt  out  CNT_W  samples accepted this run
- mismatch_cnt  out  CNT_W  mismatches this run
- first_err_idx  out  CNT_W  0-based index of first mismatching sample
- first_err_valid  out  1  first_err_idx is meaningful

Behaviour:
- Reset (async assert, sync deassert use): all outputs 0, state IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - start -> RUN. All counters, err_sticky, first_err_valid and first_err_idx are cleared on that edge.
  - Samples are ignored.
- RUN:
  - A sample is accepted on any cycle with in_valid=1, including the cycle in which stop is asserted.
  - Per accepted sample: match <= ~(ref_bit^dut_bit) and match_valid <= 1 (1-cycle latency). match_valid is 0 on non-accepting cycles; match holds its last value.
  - sample_cnt increments, saturating at all-ones.
  - On a mismatch, mismatch_cnt increments, saturating at all-ones, and err_sticky <= 1.
  - On the first mismatch only: first_err_idx <= sample_cnt value before the increment, and first_err_valid <= 1.
  - RUN -> DONE on stop.
  - RUN -> DONE when WINDOW != 0 and the accepted sample makes sample_cnt equal WINDOW. That sample is fully counted.
  - start while in RUN is ignored.
- DONE:
  - done=1; all statistics hold.
  - start -> RUN with clear, as from IDLE.
  - stop is ignored.
- Simultaneous events:
  - start+stop in IDLE or DONE: start wins.
  - start+stop in RUN: stop wins.
- Counter saturation does not end a run.
- Reset mid-run: statistics are lost and the block returns to IDLE.

Optional Feature:
- Macro: XNOR_MATCH_MONITOR_HIST_EN.
- Defined:
  - Adds parameter HIST_W (default 8) and output port hist [HIST_W-1:0].
  - hist is a shift register of per-sample mismatch bits, newest in bit 0. It shifts only on accepted samples, is cleared on the start edge, and holds in DONE.
- Undefined: no hist port and no associated logic.

Decomposition:
- Shared package xnor_chk_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a typedef for the stats bundle (sample_cnt, mismatch_cnt, first_err_idx, first_err_valid, err_sticky);
  - a localparam giving the CNT_W default.
- One natural sub-module, sat_counter: parameterized width, synchronous clear, increment enable, saturate at max. It is instantiated for sample_cnt and mismatch_cnt.

Test Plan (CNT_W=8, WINDOW=10 unless stated):
- Reset, then start; feed 10 valid samples with ref_bit == dut_bit -> DONE after the 10th, sample_cnt=10, mismatch_cnt=0, err_sticky=0, first_err_valid=0.
- Start; samples 0-9 with mismatches at indices 3 and 7 -> mismatch_cnt=2, first_err_idx=3, err_sticky=1. match is 0 one cycle after samples 3 and 7, 1 after all others.
- WINDOW=0: start; 5 samples; stop with in_valid=1 carrying a mismatch -> sample_cnt=6, mismatch_cnt=1, first_err_idx=5, state DONE.
- WINDOW=0, CNT_W=4: 20 mismatching samples -> sample_cnt=15 and mismatch_cnt=15 (saturated), first_err_idx=0, busy still 1.
- Start+stop asserted together in IDLE -> RUN. In RUN, start+stop together -> DONE. A second start from DONE clears all stats to 0.
- areset_n pulsed low mid-run after 4 samples (1 mismatch) -> all outputs 0 immediately (asynchronous), state IDLE. In-valid samples after release are ignored until start.

Source files
------------

// File: rtl/xnor_chk_pkg.sv
// rtl/xnor_chk_pkg.sv - shared types and defaults for the XNOR match monitor
// Purpose: run-state enum, statistics bundle and counter-width default used
//          by xnor_match_monitor.
// Ports:   none (package).
package xnor_chk_pkg;

  // Default counter width for the monitor.
  localparam int CNT_W_DEFAULT = 16;

  // Widest counter the statistics bundle can carry; CNT_W must not exceed it.
  localparam int CNT_W_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One run's statistics. Count fields are sized for the widest supported
  // counter; narrower instances zero-extend into them.
  typedef struct packed {
    logic [CNT_W_MAX-1:0] sample_cnt;
    logic [CNT_W_MAX-1:0] mismatch_cnt;
    logic [CNT_W_MAX-1:0] first_err_idx;
    logic                 first_err_valid;
    logic                 err_sticky;
  } stats_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Purpose: counts enabled cycles, sticks at all-ones, clears on clr.
// Ports:   clk, rst_n (async active-low), clr (sync clear, wins over inc),
//          inc (count enable), count [WIDTH-1:0].
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/xnor_match_monitor.sv
// rtl/xnor_match_monitor.sv - on-chip pass/fail monitor for a 2-input XNOR gate under test
// Purpose: registers a per-sample XNOR match of ref_bit vs dut_bit and keeps
//          run statistics over a bounded (WINDOW) or open-ended sample window.
// Ports:   clk, areset_n (async active-low); start/stop run pulses;
//          in_valid/ref_bit/dut_bit sample input; busy/done run status;
//          match_valid/match per-sample result; err_sticky, sample_cnt,
//          mismatch_cnt, first_err_idx, first_err_valid run statistics;
//          hist [HIST_W-1:0] recent mismatch bits, newest in bit 0, only when
//          XNOR_MATCH_MONITOR_HIST_EN is defined.
module xnor_match_monitor
  import xnor_chk_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int WINDOW = 0
`ifdef XNOR_MATCH_MONITOR_HIST_EN
  ,
  parameter int HIST_W = 8
`endif
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic             ref_bit,
  input  logic             dut_bit,
  output logic             busy,
  output logic             done,
  output logic             match_valid,
  output logic             match,
  output logic             err_sticky,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_valid
`ifdef XNOR_MATCH_MONITOR_HIST_EN
  ,
  output logic [HIST_W-1:0] hist
`endif
);

  state_e           state_q, state_d;
  logic             match_valid_q, match_valid_d;
  logic             match_q, match_d;
  logic             err_sticky_q, err_sticky_d;
  logic             first_err_valid_q, first_err_valid_d;
  logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;

  logic             accept;
  logic             mism;
  logic             clear;
  logic             window_hit;
  logic [CNT_W-1:0] sample_cnt_w;
  logic [CNT_W-1:0] mismatch_cnt_w;

  assign accept = (state_q == ST_RUN) && in_valid;
  assign mism   = ref_bit ^ dut_bit;
  // start is only honoured outside RUN, so the clear never meets an accept.
  assign clear  = start && (state_q != ST_RUN);

  // The sample that brings the count up to WINDOW closes the run. WINDOW
  // fits in CNT_W, so the count cannot have saturated before this point.
  assign window_hit = (WINDOW != 0) && accept &&
                      (sample_cnt_w == CNT_W'(WINDOW - 1));

  sat_counter #(.WIDTH(CNT_W)) u_sample_cnt (
    .clk   (clk),
    .rst_n (areset_n),
    .clr   (clear),
    .inc   (accept),
    .count (sample_cnt_w)
  );

  sat_counter #(.WIDTH(CNT_W)) u_mismatch_cnt (
    .clk   (clk),
    .rst_n (areset_n),
    .clr   (clear),
    .inc   (accept && mism),
    .count (mismatch_cnt_w)
  );

  // Run-state FSM. In RUN, stop wins over start; elsewhere start wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (stop || window_hit) state_d = ST_DONE;
      ST_DONE: if (start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    match_valid_d     = accept;
    match_d           = match_q;
    err_sticky_d      = err_sticky_q;
    first_err_valid_d = first_err_valid_q;
    first_err_idx_d   = first_err_idx_q;
    if (clear) begin
      err_sticky_d      = 1'b0;
      first_err_valid_d = 1'b0;
      first_err_idx_d   = '0;
    end else if (accept) begin
      match_d = ~mism;
      if (mism) begin
        err_sticky_d = 1'b1;
        if (!first_err_valid_q) begin
          first_err_valid_d = 1'b1;
          first_err_idx_d   = sample_cnt_w;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q           <= ST_IDLE;
      match_valid_q     <= 1'b0;
      match_q           <= 1'b0;
      err_sticky_q      <= 1'b0;
      first_err_valid_q <= 1'b0;
      first_err_idx_q   <= '0;
    end else begin
      state_q           <= state_d;
      match_valid_q     <= match_valid_d;
      match_q           <= match_d;
      err_sticky_q      <= err_sticky_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_idx_q   <= first_err_idx_d;
    end
  end

  // Gather the run statistics into the shared bundle; outputs are taken
  // from it so every consumer sees one consistent view.
  stats_t stats;

  always_comb begin
    stats                 = '0;
    stats.sample_cnt      = CNT_W_MAX'(sample_cnt_w);
    stats.mismatch_cnt    = CNT_W_MAX'(mismatch_cnt_w);
    stats.first_err_idx   = CNT_W_MAX'(first_err_idx_q);
    stats.first_err_valid = first_err_valid_q;
    stats.err_sticky      = err_sticky_q;
  end

  // Upper bundle bits are zero padding for narrow counters.
  logic unused_stats_pad;
  assign unused_stats_pad = ^stats;

  assign busy            = (state_q == ST_RUN);
  assign done            = (state_q == ST_DONE);
  assign match_valid     = match_valid_q;
  assign match           = match_q;
  assign err_sticky      = stats.err_sticky;
  assign sample_cnt      = stats.sample_cnt[CNT_W-1:0];
  assign mismatch_cnt    = stats.mismatch_cnt[CNT_W-1:0];
  assign first_err_idx   = stats.first_err_idx[CNT_W-1:0];
  assign first_err_valid = stats.first_err_valid;

`ifdef XNOR_MATCH_MONITOR_HIST_EN
  logic [HIST_W-1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (clear) begin
      hist_d = '0;
    end else if (accept) begin
      hist_d = (hist_q << 1) | HIST_W'(mism);
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign hist = hist_q;
`endif

endmodule

// File: tb/tb_xnor_match_monitor.sv
// tb/tb_xnor_match_monitor.sv - self-checking bench for xnor_match_monitor
module tb_xnor_match_monitor;

  localparam int HIST_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset_n = 1'b1;
  logic start = 1'b0, stop = 1'b0, in_valid = 1'b0, ref_bit = 1'b0, dut_bit = 1'b0;

  // a: CNT_W=8 WINDOW=10, b: CNT_W=8 WINDOW=0, c: CNT_W=4 WINDOW=0
  logic a_busy, a_done, a_mv, a_m, a_es, a_fev;
  logic b_busy, b_done, b_mv, b_m, b_es, b_fev;
  logic c_busy, c_done, c_mv, c_m, c_es, c_fev;
  logic [7:0] a_sc, a_mc, a_fei, b_sc, b_mc, b_fei;
  logic [3:0] c_sc, c_mc, c_fei;
`ifdef XNOR_MATCH_MONITOR_HIST_EN
  logic [HIST_W-1:0] a_hist, b_hist, c_hist;
`endif

  xnor_match_monitor #(.CNT_W(8), .WINDOW(10)) dut_a (
    .clk(clk), .areset_n(areset_n), .start(start), .stop(stop), .in_valid(in_valid),
    .ref_bit(ref_bit), .dut_bit(dut_bit), .busy(a_busy), .done(a_done),
    .match_valid(a_mv), .match(a_m), .err_sticky(a_es), .sample_cnt(a_sc),
    .mismatch_cnt(a_mc), .first_err_idx(a_fei), .first_err_valid(a_fev)
`ifdef XNOR_MATCH_MONITOR_HIST_EN
    , .hist(a_hist)
`endif
  );

  xnor_match_monitor #(.CNT_W(8), .WINDOW(0)) dut_b (
    .clk(clk), .areset_n(areset_n), .start(start), .stop(stop), .in_valid(in_valid),
    .ref_bit(ref_bit), .dut_bit(dut_bit), .busy(b_busy), .done(b_done),
    .match_valid(b_mv), .match(b_m), .err_sticky(b_es), .sample_cnt(b_sc),
    .mismatch_cnt(b_mc), .first_err_idx(b_fei), .first_err_valid(b_fev)
`ifdef XNOR_MATCH_MONITOR_HIST_EN
    , .hist(b_hist)
`endif
  );

  xnor_match_monitor #(.CNT_W(4), .WINDOW(0)) dut_c (
    .clk(clk), .areset_n(areset_n), .start(start), .stop(stop), .in_valid(in_valid),
    .ref_bit(ref_bit), .dut_bit(dut_bit), .busy(c_busy), .done(c_done),
    .match_valid(c_mv), .match(c_m), .err_sticky(c_es), .sample_cnt(c_sc),
    .mismatch_cnt(c_mc), .first_err_idx(c_fei), .first_err_valid(c_fev)
`ifdef XNOR_MATCH_MONITOR_HIST_EN
    , .hist(c_hist)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: unbounded counts, clamped to the counter range when viewed.
  int m_st[3];      // 0 idle, 1 run, 2 done
  int m_n[3];
  int m_nm[3];
  int m_first[3];   // -1 until the first mismatch of the run
  bit m_mv[3];
  bit m_m[3];
  longint unsigned m_hist[3];
  int m_window[3] = '{10, 0, 0};
  int m_max[3]    = '{255, 255, 15};

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_n[k] = 0; m_nm[k] = 0; m_first[k] = -1;
      m_mv[k] = 1'b0; m_m[k] = 1'b0; m_hist[k] = 0;
    end
  endfunction

  function automatic void model_step(input bit s, input bit p, input bit v, input bit r, input bit d);
    for (int k = 0; k < 3; k++) begin
      bit acc;
      acc = (m_st[k] == 1) && v;
      m_mv[k] = acc;
      if (acc) begin
        m_m[k] = (r == d);
        if (r != d) begin
          if (m_first[k] < 0) m_first[k] = m_n[k];
          m_nm[k]++;
        end
        m_hist[k] = (m_hist[k] << 1) | longint'(r != d);
        m_n[k]++;
      end
      if (m_st[k] != 1 && s) begin
        m_st[k] = 1; m_n[k] = 0; m_nm[k] = 0; m_first[k] = -1; m_hist[k] = 0;
      end else if (m_st[k] == 1 && (p || (acc && m_window[k] != 0 && m_n[k] == m_window[k]))) begin
        m_st[k] = 2;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_inst(input int k, input string p,
                            input logic busy, input logic done, input logic mv, input logic m,
                            input logic es, input logic fev,
                            input logic [7:0] sc, input logic [7:0] mc, input logic [7:0] fei);
    chk($sformatf("%s.busy", p), 64'(busy), 64'(m_st[k] == 1));
    chk($sformatf("%s.done", p), 64'(done), 64'(m_st[k] == 2));
    chk($sformatf("%s.match_valid", p), 64'(mv), 64'(m_mv[k]));
    chk($sformatf("%s.match", p), 64'(m), 64'(m_m[k]));
    chk($sformatf("%s.err_sticky", p), 64'(es), 64'(m_nm[k] > 0));
    chk($sformatf("%s.first_err_valid", p), 64'(fev), 64'(m_first[k] >= 0));
    chk($sformatf("%s.sample_cnt", p), 64'(sc), 64'(mn(m_n[k], m_max[k])));
    chk($sformatf("%s.mismatch_cnt", p), 64'(mc), 64'(mn(m_nm[k], m_max[k])));
    chk($sformatf("%s.first_err_idx", p), 64'(fei),
        64'((m_first[k] >= 0) ? mn(m_first[k], m_max[k]) : 0));
  endtask

  task automatic check_all();
    check_inst(0, "a", a_busy, a_done, a_mv, a_m, a_es, a_fev, a_sc, a_mc, a_fei);
    check_inst(1, "b", b_busy, b_done, b_mv, b_m, b_es, b_fev, b_sc, b_mc, b_fei);
    check_inst(2, "c", c_busy, c_done, c_mv, c_m, c_es, c_fev, 8'(c_sc), 8'(c_mc), 8'(c_fei));
`ifdef XNOR_MATCH_MONITOR_HIST_EN
    chk("a.hist", 64'(a_hist), m_hist[0] & ((64'd1 << HIST_W) - 1));
    chk("b.hist", 64'(b_hist), m_hist[1] & ((64'd1 << HIST_W) - 1));
    chk("c.hist", 64'(c_hist), m_hist[2] & ((64'd1 << HIST_W) - 1));
`endif
  endtask

  // Drive one cycle of inputs, advance the model, sample just after the edge.
  task automatic step(input bit s, input bit p, input bit v, input bit r, input bit d);
    start = s; stop = p; in_valid = v; ref_bit = r; dut_bit = d;
    model_step(s, p, v, r, d);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic async_reset();
    start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    areset_n = 1'b0;
    #2;
    model_reset();
    chk("rst.a_busy", 64'(a_busy), 64'd0);
    chk("rst.a_sc", 64'(a_sc), 64'd0);
    chk("rst.a_mc", 64'(a_mc), 64'd0);
    chk("rst.a_es", 64'(a_es), 64'd0);
    check_all();
    @(negedge clk);
    areset_n = 1'b1;
  endtask

  typedef struct {
    bit s, p, v, r, d;
    int busy, done, mv, m, sc, mc, es, fei, fev;
  } vec_t;

  vec_t tbl[$];

  initial begin
    vec_t t;
    bit mis;

    // Window of 10 all-matching samples, then a restart with mismatches at 3 and 7.
    t = '{s:1, p:0, v:0, r:0, d:0, busy:1, done:0, mv:0, m:0, sc:0, mc:0, es:0, fei:0, fev:0};
    tbl.push_back(t);
    for (int i = 0; i < 10; i++) begin
      t = '{s:0, p:0, v:1, r:bit'(i % 2), d:bit'(i % 2), busy:int'(i < 9), done:int'(i == 9),
            mv:1, m:1, sc:i + 1, mc:0, es:0, fei:0, fev:0};
      tbl.push_back(t);
    end
    t = '{s:1, p:0, v:0, r:0, d:0, busy:1, done:0, mv:0, m:1, sc:0, mc:0, es:0, fei:0, fev:0};
    tbl.push_back(t);
    for (int j = 0; j < 10; j++) begin
      mis = (j == 3) || (j == 7);
      t = '{s:0, p:0, v:1, r:bit'(j % 2), d:bit'(j % 2) ^ mis, busy:int'(j < 9), done:int'(j == 9),
            mv:1, m:int'(!mis), sc:j + 1, mc:(j >= 7) ? 2 : ((j >= 3) ? 1 : 0),
            es:int'(j >= 3), fei:(j >= 3) ? 3 : 0, fev:int'(j >= 3)};
      tbl.push_back(t);
    end

    // Power-on reset.
    #2;
    areset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    areset_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].p, tbl[i].v, tbl[i].r, tbl[i].d);
      chk($sformatf("tbl%0d.busy", i), 64'(a_busy), 64'(tbl[i].busy));
      chk($sformatf("tbl%0d.done", i), 64'(a_done), 64'(tbl[i].done));
      chk($sformatf("tbl%0d.match_valid", i), 64'(a_mv), 64'(tbl[i].mv));
      chk($sformatf("tbl%0d.match", i), 64'(a_m), 64'(tbl[i].m));
      chk($sformatf("tbl%0d.sample_cnt", i), 64'(a_sc), 64'(tbl[i].sc));
      chk($sformatf("tbl%0d.mismatch_cnt", i), 64'(a_mc), 64'(tbl[i].mc));
      chk($sformatf("tbl%0d.err_sticky", i), 64'(a_es), 64'(tbl[i].es));
      chk($sformatf("tbl%0d.first_err_idx", i), 64'(a_fei), 64'(tbl[i].fei));
      chk($sformatf("tbl%0d.first_err_valid", i), 64'(a_fev), 64'(tbl[i].fev));
    end
    step(0, 1, 0, 0, 0);

    // Open-ended run closed by a stop that carries a mismatching sample.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 1);
    step(0, 1, 1, 0, 1);
    chk("stopmis.b_sc", 64'(b_sc), 64'd6);
    chk("stopmis.b_mc", 64'(b_mc), 64'd1);
    chk("stopmis.b_fei", 64'(b_fei), 64'd5);
    chk("stopmis.b_done", 64'(b_done), 64'd1);

    // Saturation of the 4-bit counters does not end the run.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 0);
    chk("sat.c_sc", 64'(c_sc), 64'd15);
    chk("sat.c_mc", 64'(c_mc), 64'd15);
    chk("sat.c_fei", 64'(c_fei), 64'd0);
    chk("sat.c_busy", 64'(c_busy), 64'd1);
    chk("sat.b_sc", 64'(b_sc), 64'd20);
    step(0, 1, 0, 0, 0);

    // Simultaneous start+stop: start wins from IDLE, stop wins in RUN.
    @(negedge clk);
    async_reset();
    step(1, 1, 0, 0, 0);
    chk("ss.idle_busy", 64'(a_busy), 64'd1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 1, 1);
    chk("ss.a_fei", 64'(a_fei), 64'd1);
    step(1, 1, 0, 0, 0);
    chk("ss.run_done", 64'(a_done), 64'd1);
    step(1, 0, 0, 0, 0);
    chk("ss.restart_sc", 64'(a_sc), 64'd0);
    chk("ss.restart_fev", 64'(a_fev), 64'd0);
    chk("ss.restart_es", 64'(a_es), 64'd0);

    // Reset mid-run, then samples without start are ignored.
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    chk("mid.a_sc", 64'(a_sc), 64'd4);
    async_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
    chk("post.a_sc", 64'(a_sc), 64'd0);
    chk("post.a_mv", 64'(a_mv), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 25) == 0, ($urandom % 30) == 0, ($urandom % 10) < 7,
           1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
